// File: rtl/restador_display.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module  : restador_display                                              |
// | Desc    : Captures an adder/subtractor result and drives a 3-digit      |
// |           multiplexed common-anode display (sign, tens, ones).          |
// |           Define RESTADOR_DISPLAY_DEC_EN for decimal, else hex digits.  |
// | Revision: 1.0 - initial release                                         |
// +-------------------------------------------------------------------------+
module restador_display #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] S,
    input  logic       Cout,
    input  logic       select,
    output logic       valid,
    output logic       neg,
    output logic [6:0] seg,
    output logic [2:0] an
);

    localparam int unsigned    CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  c_TERM  = CW'(REFRESH_DIV - 1);
    localparam logic [6:0]     c_BLANK = 7'b1111111;
    localparam logic [6:0]     c_MINUS = 7'b0111111;

    logic [CW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    s_q, s_d;
    logic          cout_q, cout_d, sel_q, sel_d;
    logic          valid_q, valid_d, neg_q, neg_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;

    logic [4:0]    w_value;
    logic [4:0]    w_rem;
    logic [3:0]    w_tens;
    logic [3:0]    w_ones;
    logic          w_wrap;

    function automatic logic [6:0] f_glyph(input logic [3:0] d);
        case (d)
            4'h0: f_glyph = 7'b1000000;
            4'h1: f_glyph = 7'b1111001;
            4'h2: f_glyph = 7'b0100100;
            4'h3: f_glyph = 7'b0110000;
            4'h4: f_glyph = 7'b0011001;
            4'h5: f_glyph = 7'b0010010;
            4'h6: f_glyph = 7'b0000010;
            4'h7: f_glyph = 7'b1111000;
            4'h8: f_glyph = 7'b0000000;
            4'h9: f_glyph = 7'b0010000;
            4'hA: f_glyph = 7'b0001000;
            4'hB: f_glyph = 7'b0000011;
            4'hC: f_glyph = 7'b1000110;
            4'hD: f_glyph = 7'b0100001;
            4'hE: f_glyph = 7'b0000110;
            default: f_glyph = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        // A subtract result never carries into bit 4: Cout only encodes the sign.
        w_value = sel_q ? {1'b0, s_q} : {cout_q, s_q};
        w_rem   = 5'd0;
`ifdef RESTADOR_DISPLAY_DEC_EN
        if (w_value >= 5'd30) begin
            w_tens = 4'd3;
            w_rem  = w_value - 5'd30;
        end else if (w_value >= 5'd20) begin
            w_tens = 4'd2;
            w_rem  = w_value - 5'd20;
        end else if (w_value >= 5'd10) begin
            w_tens = 4'd1;
            w_rem  = w_value - 5'd10;
        end else begin
            w_tens = 4'd0;
            w_rem  = w_value;
        end
        w_ones = w_rem[3:0];
`else
        w_tens = {3'b000, w_value[4]};
        w_rem  = w_value;
        w_ones = w_rem[3:0];
`endif
    end

    always_comb begin
        w_wrap  = (presc_q == c_TERM);
        presc_d = w_wrap ? '0 : presc_q + CW'(1);
        idx_d   = idx_q;
        if (w_wrap)
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;

        s_d     = load ? S      : s_q;
        cout_d  = load ? Cout   : cout_q;
        sel_d   = load ? select : sel_q;
        valid_d = valid_q | load;
        neg_d   = load ? (select & ~Cout) : neg_q;

        // Outputs follow the pre-edge index and captured bits, one cycle behind.
        an_d  = 3'b111;
        seg_d = c_BLANK;
        if (valid_q) begin
            case (idx_q)
                2'd0: begin
                    an_d  = 3'b110;
                    seg_d = f_glyph(w_ones);
                end
                2'd1: begin
                    an_d  = 3'b101;
                    seg_d = (w_tens == 4'd0) ? c_BLANK : f_glyph(w_tens);
                end
                2'd2: begin
                    an_d  = 3'b011;
                    seg_d = neg_q ? c_MINUS : c_BLANK;
                end
                default: begin
                    an_d  = 3'b111;
                    seg_d = c_BLANK;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            s_q     <= 4'd0;
            cout_q  <= 1'b0;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
            neg_q   <= 1'b0;
            seg_q   <= c_BLANK;
            an_q    <= 3'b111;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            neg_q   <= neg_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign valid = valid_q;
    assign neg   = neg_q;
    assign seg   = seg_q;
    assign an    = an_q;

endmodule
`default_nettype wire

// File: tb/tb_restador_display.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module  : tb_restador_display                                           |
// | Desc    : Table, directed and random checks against a timeline model.   |
// | Revision: 1.0 - initial release                                         |
// +-------------------------------------------------------------------------+
module tb_restador_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] S = 4'd0;
    logic       Cout = 1'b0;
    logic       select = 1'b0;
    logic       valid, neg;
    logic [6:0] seg;
    logic [2:0] an;

    restador_display #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .load(load), .S(S), .Cout(Cout), .select(select),
        .valid(valid), .neg(neg), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    logic [6:0] GL [16];

    // Model: edges since reset, and the last captured result as a plain number.
    int m_t;
    bit m_valid;
    bit m_neg;
    int m_val;

    typedef struct {
        logic [3:0] s;
        logic       c;
        logic       sel;
        logic       neg;
        logic [6:0] sign;
        logic [6:0] tens;
        logic [6:0] ones;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_disp(output logic [2:0] a, output logic [6:0] sg);
        int idx, tens, ones;
`ifdef RESTADOR_DISPLAY_DEC_EN
        tens = m_val / 10;
        ones = m_val % 10;
`else
        tens = m_val / 16;
        ones = m_val % 16;
`endif
        idx = (m_t / DIV) % 3;
        a  = 3'b111;
        sg = 7'b1111111;
        if (m_valid) begin
            if (idx == 0) begin
                a  = 3'b110;
                sg = GL[ones];
            end else if (idx == 1) begin
                a  = 3'b101;
                sg = (tens == 0) ? 7'b1111111 : GL[tens];
            end else begin
                a  = 3'b011;
                sg = m_neg ? 7'b0111111 : 7'b1111111;
            end
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_valid = 0; m_neg = 0; m_val = 0;
    endtask

    task automatic tick(input bit l, input logic [3:0] s, input bit c, input bit sl);
        logic [2:0] ea;
        logic [6:0] es;
        load = l; S = s; Cout = c; select = sl;
        model_disp(ea, es);
        if (l) begin
            m_valid = 1;
            m_neg   = sl && !c;
            m_val   = sl ? int'(s) : int'(s) + (c ? 16 : 0);
        end
        m_t++;
        @(posedge clk);
        #1;
        chk("valid", {31'd0, valid}, {31'd0, m_valid});
        chk("neg",   {31'd0, neg},   {31'd0, m_neg});
        chk("an",    {29'd0, an},    {29'd0, ea});
        chk("seg",   {25'd0, seg},   {25'd0, es});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; load = 1'b0;
        #1;
        chk("rst_an",    {29'd0, an},    32'b111);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] seen_sign, seen_tens, seen_ones;
        bit found, saw_one;

        GL[0] = 7'b1000000; GL[1] = 7'b1111001; GL[2] = 7'b0100100; GL[3] = 7'b0110000;
        GL[4] = 7'b0011001; GL[5] = 7'b0010010; GL[6] = 7'b0000010; GL[7] = 7'b1111000;
        GL[8] = 7'b0000000; GL[9] = 7'b0010000; GL[10] = 7'b0001000; GL[11] = 7'b0000011;
        GL[12] = 7'b1000110; GL[13] = 7'b0100001; GL[14] = 7'b0000110; GL[15] = 7'b0001110;

`ifdef RESTADOR_DISPLAY_DEC_EN
        tbl[0] = '{4'b0011, 1'b0, 1'b1, 1'b1, 7'b0111111, 7'b1111111, 7'b0110000};
        tbl[1] = '{4'b1100, 1'b1, 1'b0, 1'b0, 7'b1111111, 7'b0100100, 7'b0000000};
        tbl[2] = '{4'b0101, 1'b1, 1'b1, 1'b0, 7'b1111111, 7'b1111111, 7'b0010010};
        tbl[3] = '{4'b1111, 1'b0, 1'b0, 1'b0, 7'b1111111, 7'b1111001, 7'b0010010};
        tbl[4] = '{4'b0000, 1'b1, 1'b1, 1'b0, 7'b1111111, 7'b1111111, 7'b1000000};
        tbl[5] = '{4'b1111, 1'b1, 1'b0, 1'b0, 7'b1111111, 7'b0110000, 7'b1111001};
`else
        tbl[0] = '{4'b0011, 1'b0, 1'b1, 1'b1, 7'b0111111, 7'b1111111, 7'b0110000};
        tbl[1] = '{4'b1100, 1'b1, 1'b0, 1'b0, 7'b1111111, 7'b1111001, 7'b1000110};
        tbl[2] = '{4'b0101, 1'b1, 1'b1, 1'b0, 7'b1111111, 7'b1111111, 7'b0010010};
        tbl[3] = '{4'b1111, 1'b0, 1'b0, 1'b0, 7'b1111111, 7'b1111111, 7'b0001110};
        tbl[4] = '{4'b0000, 1'b1, 1'b1, 1'b0, 7'b1111111, 7'b1111111, 7'b1000000};
        tbl[5] = '{4'b1111, 1'b1, 1'b0, 1'b0, 7'b1111111, 7'b1111001, 7'b0001110};
`endif

        // Reset with no load: fully blank for well over 12 cycles.
        model_reset();
        #12;
        chk("por_seg", {25'd0, seg}, 32'b1111111);
        do_reset();
        for (int i = 0; i < 14; i++) tick(0, 4'd0, 0, 0);

        // Table vectors: capture, then observe every digit of one full scan.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            tick(1, tbl[v].s, tbl[v].c, tbl[v].sel);
            seen_sign = 7'b1010101; seen_tens = 7'b1010101; seen_ones = 7'b1010101;
            for (int k = 0; k < 3 * DIV + 1; k++) begin
                tick(0, 4'd0, 0, 0);
                case (an)
                    3'b110: seen_ones = seg;
                    3'b101: seen_tens = seg;
                    3'b011: seen_sign = seg;
                    default: ;
                endcase
            end
            chk($sformatf("tbl%0d_neg", v),  {31'd0, neg},       {31'd0, tbl[v].neg});
            chk($sformatf("tbl%0d_sign", v), {25'd0, seen_sign}, {25'd0, tbl[v].sign});
            chk($sformatf("tbl%0d_tens", v), {25'd0, seen_tens}, {25'd0, tbl[v].tens});
            chk($sformatf("tbl%0d_ones", v), {25'd0, seen_ones}, {25'd0, tbl[v].ones});
        end

        // Back-to-back loads during the tens slot: "1" must never be shown.
        do_reset();
        for (int i = 0; i < DIV; i++) tick(0, 4'd0, 0, 0);
        tick(1, 4'b0001, 1, 1);
        tick(1, 4'b0101, 1, 1);
        saw_one = 0;
        for (int k = 0; k < 3 * DIV + 2; k++) begin
            tick(0, 4'd0, 0, 0);
            if (seg == 7'b1111001) saw_one = 1;
        end
        chk("b2b_no_one", {31'd0, saw_one}, 32'd0);

        // Load coinciding with a prescaler wrap.
        do_reset();
        for (int i = 0; i < DIV - 1; i++) tick(0, 4'd0, 0, 0);
        tick(1, 4'b0111, 0, 1);
        chk("wrap_an", {29'd0, an}, 32'b111);
        tick(0, 4'd0, 0, 0);
        chk("wrap_an1", {29'd0, an}, 32'b101);

        // Reset while the tens digit is active.
        do_reset();
        tick(1, 4'b1100, 1, 0);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(0, 4'd0, 0, 0);
            if (an == 3'b101) found = 1;
        end
        chk("mid_found", {31'd0, found}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_an",    {29'd0, an},    32'b111);
        chk("mid_valid", {31'd0, valid}, 32'd0);
        chk("mid_seg",   {25'd0, seg},   32'b1111111);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick(1, 4'b0000, 1, 1);
        tick(0, 4'd0, 0, 0);
        chk("mid_re_an",  {29'd0, an},  32'b110);
        chk("mid_re_seg", {25'd0, seg}, 32'b1000000);
        chk("mid_re_neg", {31'd0, neg}, 32'd0);
        for (int k = 0; k < 2 * DIV; k++) tick(0, 4'd0, 0, 0);

        // Random loads against the model.
        do_reset();
        for (int k = 0; k < 300; k++)
            tick(($urandom % 4) == 0, 4'($urandom), 1'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
